// File: rtl/opcode_rr_arbiter_pkg.sv
// Shared types for the round-robin opcode arbiter:
// address words, the split opcode and the output-register state.
package opcode_rr_arbiter_pkg;

    typedef logic [15:0] word_t;
    typedef logic [31:0] dword_t;

    typedef struct packed {
        word_t instruction;
        word_t absolute;
    } opcode_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/opcode_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or
// above rr_ptr, wrapping to 0. Shared by arbiters in the codebase.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W:0] NREQ = (SRC_W+1)'(NUM_REQ);

    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // one extra bit so the wrap subtraction cannot overflow
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = sum[SRC_W-1:0];
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
        grant[winner] = any_valid;
    end

endmodule

// File: rtl/opcode_rr_arbiter.sv
// Round-robin arbiter in front of the opcode split; the winning
// address is split into instruction/absolute and registered.
module opcode_rr_arbiter
    import opcode_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  dword_t [NUM_REQ-1:0]       req_address,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       opcode_valid,
    input  logic                       opcode_ready,
    output opcode_t                    opcode,
    output logic [$clog2(NUM_REQ)-1:0] opcode_src,
    output logic [CNT_W-1:0]           issue_count
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] src_q, src_d;
    opcode_t          opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   winner;
    logic               any_valid;
    logic               fire;
    logic               can_load;
    logic               load;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .winner   (winner),
        .any_valid(any_valid)
    );

    assign opcode_valid = (state_q == FULL);
    assign fire         = opcode_valid & opcode_ready;
    assign can_load     = (state_q == EMPTY) | fire;
    assign load         = can_load & any_valid;
    // gate with rst_n so no grant is seen while reset is held
    assign req_ready    = grant & {NUM_REQ{can_load & rst_n}};

    assign opcode       = opcode_q;
    assign opcode_src   = src_q;
    assign issue_count  = cnt_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        src_d    = src_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q + CNT_W'(fire);

        if (load) begin
            opcode_d.instruction = req_address[winner][31:16];
            opcode_d.absolute    = req_address[winner][15:0];
            src_d                = winner;
            rr_ptr_d = (winner == LAST) ? '0 : winner + 1'b1;
        end

        unique case (state_q)
            EMPTY: begin
                if (any_valid) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (opcode_ready && !any_valid) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            src_q    <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            src_q    <= src_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/opcode_rr_arbiter.md
Name: opcode_rr_arbiter

Overview:
- Shares one opcode-split stage between NUM_REQ requesters, each presenting a dword_t address.
- Round-robin arbitration selects one requester; its address is split into opcode_t (instruction = bits 31:16, absolute = bits 15:0).
- The result is registered and offered downstream on a valid/ready handshake.
- Sits between the address sources and the opcode consumer; it is the only path to the opcode datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 16, width of the issued-opcode counter.
- SRC_W, $clog2(NUM_REQ), width of the source index (localparam, not overridable).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_address  input  NUM_REQ x dword_t  per-requester address (packed array).
- req_ready  output  NUM_REQ  one-hot grant; asserted in the cycle the address is captured.
- opcode_valid  output  1  output register holds a valid opcode.
- opcode_ready  input  1  consumer accepts the opcode.
- opcode  output  opcode_t  registered split result.
- opcode_src  output  SRC_W  index of the requester that produced the opcode.
- issue_count  output  CNT_W  number of completed downstream handshakes.

Behaviour:
- Interface decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: opcode_valid=0, opcode=0, opcode_src=0, issue_count=0, rr_ptr=0, state=EMPTY.
- req_ready is combinational and is 0 whenever rst_n=0.
- FSM has two states:
  - EMPTY: output register free.
  - FULL: output register holds an opcode, opcode_valid=1.
- can_load = (state==EMPTY) | (opcode_valid & opcode_ready).
- Arbitration:
  - Scan requesters from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
  - First i with req_valid[i] wins.
  - req_ready[winner] = can_load; all other req_ready bits are 0.
  - At most one req_ready bit is high in any cycle.
- Capture, on a rising edge with can_load and any req_valid:
  - opcode <= {req_address[w][31:16], req_address[w][15:0]}.
  - opcode_src <= w.
  - rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1.
  - state <= FULL.
- Drain:
  - FULL with opcode_ready=1 and no req_valid -> EMPTY, opcode_valid=0 next cycle.
  - FULL with opcode_ready=1 and a req_valid present -> stays FULL; the new opcode loads in the same edge (back-to-back, 1 opcode/cycle).
- Stall: FULL with opcode_ready=0 holds opcode, opcode_src and opcode_valid stable; all req_ready=0.
- No grant leaves rr_ptr unchanged.
- Latency: request captured at edge N, opcode_valid high after edge N. Latency is 1 cycle; there is no combinational path from req_address to opcode.
- issue_count increments on each opcode_valid & opcode_ready edge and wraps from 2^CNT_W-1 to 0.
- Requester rule: hold req_valid and req_address stable until req_ready. Dropping req_valid early is legal; no capture occurs.
- Reset asserted mid-operation: the held opcode is discarded, all outputs return to reset values immediately (async), and rr_ptr returns to 0.
- opcode_ready while EMPTY is ignored; issue_count does not change.

Decomposition:
- Package definitions holds:
  - word_t (16-bit logic).
  - dword_t (32-bit logic).
  - opcode_t (packed struct: word_t instruction, word_t absolute).
  - New enum arb_state_t {EMPTY, FULL}.
- Sub-module rr_pick (combinational, NUM_REQ param):
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant, winner index, any_valid.
  - Reusable by other arbiters in the codebase.
- The split is a direct field assignment in the top module; no separate instance.

Test Plan:
1. Reset with requester 0 valid, address 32'hDEADBEEF, opcode_ready=1 -> first edge after release: req_ready=4'b0001. Next cycle: opcode.instruction=16'hDEAD, opcode.absolute=16'hBEEF, opcode_src=0, opcode_valid=1.
2. All four requesters valid continuously, opcode_ready=1, addresses 32'h0000_1111 * (i+1) -> grants rotate 0,1,2,3,0. One opcode per cycle. issue_count reaches 5 after five handshakes.
3. Backpressure: FULL with opcode 16'hCAFE/16'hF00D, opcode_ready=0 for 3 cycles -> outputs stable, req_ready=0. On release, the next requester in rotation is granted in the same cycle.
4. Wrap: rr_ptr=3, requesters 1 and 3 valid -> grant 3 first, then 1 (skips 0 and 2). rr_ptr goes to 0, then 2.
5. Counter wrap with CNT_W=4 -> 16 handshakes return issue_count to 0.
6. Assert rst_n low mid-stall with opcode_valid=1 -> opcode_valid, opcode, issue_count go to 0 before the next clock edge. No grant while rst_n=0.
